window_reg_bank: RTL and testbench

Parametrised bank of DEPTH registers, each WIDTH bits, with four operating modes: hold, indexed load, serial shift and clear. Fill tracking reports when a complete pixel window has been shifted in. It sits between the pixel stream and the FAST ring/score logic. It replaces single load-enable registers wherever a multi-entry pixel window or a ring of circle samples must be captured, shifted or rewritten.

---
 rtl/window_pkg.sv | 16 +
 rtl/window_entry.sv | 37 +++
 rtl/window_reg_bank.sv | 99 +++++++++
 tb/tb_window_reg_bank.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// Shared mode encoding for the pixel window register bank and the ring sampler FSM.
package window_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    WM_HOLD  = MODE_HOLD,
    WM_LOAD  = MODE_LOAD,
    WM_SHIFT = MODE_SHIFT,
    WM_CLEAR = MODE_CLEAR
  } wmode_t;

endpackage

// File: rtl/window_entry.sv
// One WIDTH-bit window entry: holds, takes an indexed load, takes its neighbour's
// value on a shift, or returns to the reset value on clear.
module window_entry
  import window_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  wmode_t           mode_i,
  input  logic             load_hit_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic [WIDTH-1:0] shift_data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] dataQ, dataD;

  always_comb begin
    dataD = dataQ;
    unique case (mode_i)
      WM_HOLD:  dataD = dataQ;
      WM_LOAD:  if (load_hit_i) dataD = load_data_i;
      WM_SHIFT: dataD = shift_data_i;
      WM_CLEAR: dataD = RESET;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) dataQ <= RESET;
    else       dataQ <= dataD;
  end

  assign data_o = dataQ;

endmodule

// File: rtl/window_reg_bank.sv
// Bank of DEPTH pixel registers with hold/load/shift/clear modes, random read,
// flattened window output and fill tracking for the FAST circle sampler.
module window_reg_bank
  import window_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 16,
  parameter logic [WIDTH-1:0] RESET = '0,
  localparam int              IDXW  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [IDXW-1:0]        load_idx,
  input  logic [WIDTH-1:0]       load_data,
  input  logic [WIDTH-1:0]       shift_in,
  output logic [WIDTH-1:0]       shift_out,
  input  logic [IDXW-1:0]        rd_idx,
  output logic [WIDTH-1:0]       rd_data,
  output logic [WIDTH*DEPTH-1:0] window,
  output logic [IDXW:0]          fill_count,
  output logic                   full,
  output logic                   idx_err
);

  localparam logic [IDXW:0] DEPTH_C = (IDXW + 1)'(DEPTH);
  localparam logic [IDXW:0] ONE_C   = (IDXW + 1)'(1);

  wmode_t           opMode;
  logic [WIDTH-1:0] entryQ [DEPTH];
  logic [IDXW:0]    fillCntQ, fillCntD;
  logic             idxErrQ, idxErrD;
  logic [WIDTH-1:0] rdData;

  assign opMode = wmode_t'(mode);

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [WIDTH-1:0] shiftSrc;
    if (i == 0) begin : g_head
      assign shiftSrc = shift_in;
    end else begin : g_body
      assign shiftSrc = entryQ[i-1];
    end

    window_entry #(
      .WIDTH (WIDTH),
      .RESET (RESET)
    ) u_entry (
      .clk_i        (clk),
      .rst_i        (rst),
      .mode_i       (opMode),
      .load_hit_i   (load_idx == IDXW'(i)),
      .load_data_i  (load_data),
      .shift_data_i (shiftSrc),
      .data_o       (entryQ[i])
    );

    assign window[i*WIDTH +: WIDTH] = entryQ[i];
  end

  // Out-of-range loads never match an entry, so they only raise the sticky error.
  always_comb begin
    fillCntD = fillCntQ;
    idxErrD  = idxErrQ;
    unique case (opMode)
      WM_HOLD:  ;
      WM_LOAD:  if ({1'b0, load_idx} >= DEPTH_C) idxErrD = 1'b1;
      WM_SHIFT: if (fillCntQ != DEPTH_C) fillCntD = fillCntQ + ONE_C;
      WM_CLEAR: begin
        fillCntD = '0;
        idxErrD  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fillCntQ <= '0;
      idxErrQ  <= 1'b0;
    end else begin
      fillCntQ <= fillCntD;
      idxErrQ  <= idxErrD;
    end
  end

  always_comb begin
    rdData = RESET;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == IDXW'(i)) rdData = entryQ[i];
    end
  end

  assign rd_data    = rdData;
  assign shift_out  = entryQ[DEPTH-1];
  assign fill_count = fillCntQ;
  assign full       = (fillCntQ == DEPTH_C);
  assign idx_err    = idxErrQ;

endmodule

// File: tb/tb_window_reg_bank.sv
// Directed bench for window_reg_bank: default bank (A), DEPTH=12 bank (B) and
// RESET=8'hFF bank (C) share one stimulus stream.
module tb_window_reg_bank;
  import window_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [3:0]  loadIdx, rdIdx;
  logic [7:0]  loadData, shiftIn;

  logic [7:0]   shiftOutA, rdDataA, shiftOutB, rdDataB, shiftOutC, rdDataC;
  logic [127:0] windowA, windowC;
  logic [95:0]  windowB;
  logic [4:0]   fillA, fillB, fillC;
  logic         fullA, fullB, fullC, idxErrA, idxErrB, idxErrC;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] m;
    logic [3:0] li;
    logic [7:0] ld;
    logic [7:0] si;
    logic [3:0] ri;
    logic [7:0] expSo;
    logic [7:0] expRd;
    logic [4:0] expFill;
    logic       expFull;
  } vec_t;

  vec_t         vecs [20];
  logic [127:0] expWin;
  logic [95:0]  expWinB;

  always #5 clk = ~clk;

  window_reg_bank #(.WIDTH(8), .DEPTH(16), .RESET(8'h00)) dutA (
    .clk(clk), .rst(rst), .mode(mode), .load_idx(loadIdx), .load_data(loadData),
    .shift_in(shiftIn), .shift_out(shiftOutA), .rd_idx(rdIdx), .rd_data(rdDataA),
    .window(windowA), .fill_count(fillA), .full(fullA), .idx_err(idxErrA)
  );

  window_reg_bank #(.WIDTH(8), .DEPTH(12), .RESET(8'h00)) dutB (
    .clk(clk), .rst(rst), .mode(mode), .load_idx(loadIdx), .load_data(loadData),
    .shift_in(shiftIn), .shift_out(shiftOutB), .rd_idx(rdIdx), .rd_data(rdDataB),
    .window(windowB), .fill_count(fillB), .full(fullB), .idx_err(idxErrB)
  );

  window_reg_bank #(.WIDTH(8), .DEPTH(16), .RESET(8'hFF)) dutC (
    .clk(clk), .rst(rst), .mode(mode), .load_idx(loadIdx), .load_data(loadData),
    .shift_in(shiftIn), .shift_out(shiftOutC), .rd_idx(rdIdx), .rd_data(rdDataC),
    .window(windowC), .fill_count(fillC), .full(fullC), .idx_err(idxErrC)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle's inputs and returns 1ns after the capturing edge.
  task automatic applyStimulus(input logic r, input logic [1:0] m, input logic [3:0] li,
                               input logic [7:0] ld, input logic [7:0] si, input logic [3:0] ri);
    rst      = r;
    mode     = m;
    loadIdx  = li;
    loadData = ld;
    shiftIn  = si;
    rdIdx    = ri;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = MODE_HOLD; loadIdx = '0; loadData = '0; shiftIn = '0; rdIdx = '0;

    for (int i = 0; i < 16; i++)
      vecs[i] = '{MODE_SHIFT, 4'd0, 8'd0, 8'(i + 1), 4'd0, 8'd0, 8'(i + 1), 5'(i + 1), (i == 15)};
    vecs[16] = '{MODE_SHIFT, 4'd0, 8'd0, 8'hAA, 4'd15, 8'd1, 8'd2,    5'd16, 1'b1};
    vecs[17] = '{MODE_LOAD,  4'd5, 8'h3C, 8'd0, 4'd5,  8'd2, 8'h3C,   5'd16, 1'b1};
    vecs[18] = '{MODE_HOLD,  4'd0, 8'd0, 8'd0,  4'd4,  8'd2, 8'd13,   5'd16, 1'b1};
    vecs[19] = '{MODE_HOLD,  4'd0, 8'd0, 8'd0,  4'd6,  8'd2, 8'd11,   5'd16, 1'b1};

    // Reset
    applyStimulus(1'b1, MODE_HOLD, 4'd0, 8'd0, 8'd0, 4'd0);
    applyStimulus(1'b1, MODE_HOLD, 4'd0, 8'd0, 8'd0, 4'd0);
    rst = 1'b0;
    checkOutput("reset_windowA", windowA, '0);
    checkOutput("reset_fillA", fillA, 0);
    checkOutput("reset_fullA", fullA, 0);
    checkOutput("reset_idxErrA", idxErrA, 0);
    checkOutput("reset_shiftOutA", shiftOutA, 0);
    checkOutput("reset_windowC", windowC, {128{1'b1}});
    checkOutput("reset_shiftOutC", shiftOutC, 8'hFF);
    checkOutput("reset_rdDataC", rdDataC, 8'hFF);

    // Fill, saturation, indexed load
    for (int v = 0; v < 20; v++) begin
      rst = 1'b0; mode = vecs[v].m; loadIdx = vecs[v].li; loadData = vecs[v].ld;
      shiftIn = vecs[v].si; rdIdx = vecs[v].ri;
      #1;
      checkOutput($sformatf("vec%0d_shiftOut", v), shiftOutA, vecs[v].expSo);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_rdData", v), rdDataA, vecs[v].expRd);
      checkOutput($sformatf("vec%0d_fill", v), fillA, vecs[v].expFill);
      checkOutput($sformatf("vec%0d_full", v), fullA, vecs[v].expFull);
    end
    expWin = '0;
    expWin[7:0] = 8'hAA;
    for (int k = 1; k < 16; k++) expWin[k*8 +: 8] = 8'(17 - k);
    expWin[5*8 +: 8] = 8'h3C;
    checkOutput("fill_windowA", windowA, expWin);
    checkOutput("fill_idxErrA", idxErrA, 0);

    // Out-of-range load on the DEPTH=12 bank
    applyStimulus(1'b1, MODE_HOLD, 4'd0, 8'd0, 8'd0, 4'd0);
    applyStimulus(1'b0, MODE_SHIFT, 4'd0, 8'd0, 8'h21, 4'd0);
    applyStimulus(1'b0, MODE_SHIFT, 4'd0, 8'd0, 8'h22, 4'd0);
    applyStimulus(1'b0, MODE_SHIFT, 4'd0, 8'd0, 8'h23, 4'd0);
    applyStimulus(1'b0, MODE_LOAD, 4'd13, 8'h55, 8'd0, 4'd13);
    expWinB = '0;
    expWinB[23:0] = 24'h212223;
    checkOutput("oor_windowB", windowB, expWinB);
    checkOutput("oor_idxErrB", idxErrB, 1);
    checkOutput("oor_rdDataB", rdDataB, 0);
    checkOutput("oor_idxErrA", idxErrA, 0);
    applyStimulus(1'b0, MODE_HOLD, 4'd0, 8'd0, 8'd0, 4'd0);
    checkOutput("oor_hold_idxErrB", idxErrB, 1);
    applyStimulus(1'b0, MODE_SHIFT, 4'd0, 8'd0, 8'h24, 4'd0);
    checkOutput("oor_shift_idxErrB", idxErrB, 1);
    checkOutput("oor_shift_fillB", fillB, 4);
    applyStimulus(1'b0, MODE_LOAD, 4'd11, 8'h66, 8'd0, 4'd11);
    checkOutput("last_load_rdDataB", rdDataB, 8'h66);
    checkOutput("last_load_idxErrB", idxErrB, 1);
    applyStimulus(1'b0, MODE_CLEAR, 4'd0, 8'd0, 8'd0, 4'd0);
    checkOutput("clear_idxErrB", idxErrB, 0);
    checkOutput("clear_fillB", fillB, 0);
    checkOutput("clear_windowB", windowB, '0);

    // Clear mid-fill, then reset mid-fill
    for (int pass = 0; pass < 2; pass++) begin
      for (int s = 0; s < 7; s++) applyStimulus(1'b0, MODE_SHIFT, 4'd0, 8'd0, 8'(8'h31 + s), 4'd3);
      checkOutput($sformatf("mid%0d_fillA", pass), fillA, 7);
      checkOutput($sformatf("mid%0d_rdDataA", pass), rdDataA, 8'h34);
      if (pass == 0) applyStimulus(1'b0, MODE_CLEAR, 4'd0, 8'd0, 8'd0, 4'd3);
      else           applyStimulus(1'b1, MODE_SHIFT, 4'd0, 8'd0, 8'h77, 4'd3);
      checkOutput($sformatf("mid%0d_windowA", pass), windowA, '0);
      checkOutput($sformatf("mid%0d_fillA_after", pass), fillA, 0);
      checkOutput($sformatf("mid%0d_fullA_after", pass), fullA, 0);
      checkOutput($sformatf("mid%0d_windowC", pass), windowC, {128{1'b1}});
      checkOutput($sformatf("mid%0d_rdDataC", pass), rdDataC, 8'hFF);
    end

    // HOLD stability with noisy inputs
    for (int s = 0; s < 5; s++) applyStimulus(1'b0, MODE_SHIFT, 4'd0, 8'd0, 8'(8'h10 + s), 4'd0);
    expWin = '0;
    expWin[39:0] = 40'h1011121314;
    for (int h = 0; h < 10; h++) begin
      applyStimulus(1'b0, MODE_HOLD, 4'($urandom_range(15)), 8'($urandom), 8'($urandom), 4'd0);
      checkOutput($sformatf("hold%0d_windowA", h), windowA, expWin);
      checkOutput($sformatf("hold%0d_fillA", h), fillA, 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
